// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb3_rr_pkg.sv
// Shared definitions for the three-requester round-robin arbiter.
//   owner_t       : 2-bit owner code, 0 = none, 1..3 = requester index
//   ST_IDLE/ST_OWN: FSM state codes
//   owner_onehot  : owner code -> one-hot grant vector (bit 0 = requester 1)
package gf180mcu_fd_sc_mcu9t5v0__arb3_rr_pkg;

  localparam int unsigned N_REQ = 3;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_1    = 2'd1;
  localparam owner_t OWN_2    = 2'd2;
  localparam owner_t OWN_3    = 2'd3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  function automatic logic [N_REQ-1:0] owner_onehot(input owner_t o);
    logic [N_REQ-1:0] oh;
    oh = '0;
    if (o != OWN_NONE) oh[o - 2'd1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb3_rr_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   REQ1..REQ3 : requests, driven by the master side
//   GNT1..GNT3 : one-hot registered grants, driven by the arbiter (slave side)
//   ZN         : registered active-low "any grant" flag
interface gf180mcu_fd_sc_mcu9t5v0__arb3_rr_if;

  logic REQ1;
  logic REQ2;
  logic REQ3;
  logic GNT1;
  logic GNT2;
  logic GNT3;
  logic ZN;

  modport master (
    output REQ1, REQ2, REQ3,
    input  GNT1, GNT2, GNT3, ZN
  );

  modport slave (
    input  REQ1, REQ2, REQ3,
    output GNT1, GNT2, GNT3, ZN
  );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb3_rr_pick.sv
// Rotating-priority selector, purely combinational.
//   req    : request vector (bit 0 = requester 1)
//   ptr    : last owner; search starts at ptr+1 and wraps over 1..3
//   excl   : requesters not eligible this round
//   winner : selected requester code, OWN_NONE when nobody is eligible
module gf180mcu_fd_sc_mcu9t5v0__arb3_rr_pick
  import gf180mcu_fd_sc_mcu9t5v0__arb3_rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  owner_t           ptr,
  input  logic [N_REQ-1:0] excl,
  output owner_t           winner
);

  logic [N_REQ-1:0] avail;

  assign avail = req & ~excl;

  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = OWN_NONE;
    // Visit candidates in priority order; the first available one wins.
    for (int i = 1; i <= int'(N_REQ); i++) begin
      idx = (int'(ptr) + i - 1) % int'(N_REQ);
      if (!found && avail[idx[1:0]]) begin
        found  = 1'b1;
        winner = owner_t'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb3_rr.sv
// Three-requester round-robin arbiter with bounded hold time.
//   CLK : rising-edge clock
//   RN  : asynchronous active-low reset
//   bus : slave side of the request/grant bundle (REQ1..3 in, GNT1..3/ZN out)
// HOLD_MAX bounds how long one owner keeps the grant while others wait; 0 disables it.
module gf180mcu_fd_sc_mcu9t5v0__arb3_rr
  import gf180mcu_fd_sc_mcu9t5v0__arb3_rr_pkg::*;
#(
  parameter int unsigned  HOLD_MAX = 16,
  localparam int unsigned CW       = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1)
) (
  input logic                                 CLK,
  input logic                                 RN,
  gf180mcu_fd_sc_mcu9t5v0__arb3_rr_if.slave   bus
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic          TO_EN    = (HOLD_MAX != 0);

  logic             state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           ptr_q, ptr_d;
  owner_t           winner;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] req, owner_oh, gnt_q, gnt_d;
  logic             zn_q;
  logic             owner_req, others_req, timeout;

  assign req        = {bus.REQ3, bus.REQ2, bus.REQ1};
  assign owner_oh   = owner_onehot(owner_q);
  assign owner_req  = |(req & owner_oh);
  assign others_req = |(req & ~owner_oh);
  // >= rather than ==: once saturated with nobody waiting, a later requester
  // still preempts at its first edge instead of being starved.
  assign timeout    = TO_EN && (cnt_q >= CNT_LAST) && others_req;

  // The owner is excluded so a timeout always hands over to someone else.
  gf180mcu_fd_sc_mcu9t5v0__arb3_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .excl   (owner_oh),
    .winner (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          state_d = ST_OWN;
          owner_d = winner;
          ptr_d   = winner;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!owner_req || timeout) begin
          cnt_d = '0;
          if (winner != OWN_NONE) begin
            // Zero-idle handover: old grant drops and new one rises on the same edge.
            owner_d = winner;
            ptr_d   = winner;
          end else begin
            owner_d = OWN_NONE;
            state_d = ST_IDLE;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign gnt_d = owner_onehot(owner_d);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      ptr_q   <= OWN_3;
      cnt_q   <= '0;
      gnt_q   <= '0;
      zn_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      zn_q    <= ~|gnt_d;
    end
  end

  assign bus.GNT1 = gnt_q[0];
  assign bus.GNT2 = gnt_q[1];
  assign bus.GNT3 = gnt_q[2];
  assign bus.ZN   = zn_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__arb3_rr.sv
// Self-checking bench: three arbiter instances (HOLD_MAX = 16, 4, 0) sharing clock and reset.
module tb_gf180mcu_fd_sc_mcu9t5v0__arb3_rr;

  logic clk;
  logic rn;

  gf180mcu_fd_sc_mcu9t5v0__arb3_rr_if if16 ();
  gf180mcu_fd_sc_mcu9t5v0__arb3_rr_if if4 ();
  gf180mcu_fd_sc_mcu9t5v0__arb3_rr_if if0 ();

  gf180mcu_fd_sc_mcu9t5v0__arb3_rr #(.HOLD_MAX(16)) dut16 (.CLK(clk), .RN(rn), .bus(if16));
  gf180mcu_fd_sc_mcu9t5v0__arb3_rr #(.HOLD_MAX(4))  dut4  (.CLK(clk), .RN(rn), .bus(if4));
  gf180mcu_fd_sc_mcu9t5v0__arb3_rr #(.HOLD_MAX(0))  dut0  (.CLK(clk), .RN(rn), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;   // {REQ3, REQ2, REQ1}
    logic [2:0] gnt;   // {GNT3, GNT2, GNT1}
    logic       zn;
  } vec_t;

  vec_t vecs [14];
  int   n_total = 0;
  int   n_pass  = 0;

  // Outputs packed as {GNT3, GNT2, GNT1, ZN}.
  function automatic logic [3:0] out16();
    return {if16.GNT3, if16.GNT2, if16.GNT1, if16.ZN};
  endfunction
  function automatic logic [3:0] out4();
    return {if4.GNT3, if4.GNT2, if4.GNT1, if4.ZN};
  endfunction
  function automatic logic [3:0] out0();
    return {if0.GNT3, if0.GNT2, if0.GNT1, if0.ZN};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got gnt/zn=%b, expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  initial begin
    int bad;

    // Rotation table for HOLD_MAX=16, starting from the post-reset pointer (3).
    vecs[0]  = '{3'b111, 3'b001, 1'b0};
    vecs[1]  = '{3'b110, 3'b010, 1'b0};
    vecs[2]  = '{3'b110, 3'b010, 1'b0};
    vecs[3]  = '{3'b100, 3'b100, 1'b0};
    vecs[4]  = '{3'b101, 3'b100, 1'b0};
    vecs[5]  = '{3'b011, 3'b001, 1'b0};
    vecs[6]  = '{3'b010, 3'b010, 1'b0};
    vecs[7]  = '{3'b000, 3'b000, 1'b1};
    vecs[8]  = '{3'b100, 3'b100, 1'b0};
    vecs[9]  = '{3'b111, 3'b100, 1'b0};
    vecs[10] = '{3'b011, 3'b001, 1'b0};
    vecs[11] = '{3'b010, 3'b010, 1'b0};
    vecs[12] = '{3'b101, 3'b100, 1'b0};
    vecs[13] = '{3'b000, 3'b000, 1'b1};

    // Reset held with requests asserted.
    rn = 1'b0;
    {if16.REQ3, if16.REQ2, if16.REQ1} = 3'b111;
    {if4.REQ3, if4.REQ2, if4.REQ1}    = 3'b000;
    {if0.REQ3, if0.REQ2, if0.REQ1}    = 3'b011;
    step();
    step();
    check("reset_16", out16(), 4'b0001);
    check("reset_0", out0(), 4'b0001);
    rn = 1'b1;

    // Table-driven rotation on HOLD_MAX=16.
    for (int i = 0; i < 14; i++) begin
      {if16.REQ3, if16.REQ2, if16.REQ1} = vecs[i].req;
      step();
      check($sformatf("rot_%0d", i), out16(), {vecs[i].gnt, vecs[i].zn});
    end

    // Single requester for 40 cycles: no preemption.
    {if16.REQ3, if16.REQ2, if16.REQ1} = 3'b010;
    step();
    check("single_first", out16(), 4'b0100);
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      step();
      if (out16() !== 4'b0100) bad++;
    end
    check_int("single_hold_bad_cycles", bad, 0);
    {if16.REQ3, if16.REQ2, if16.REQ1} = 3'b000;
    #2;
    check("no_comb_path", out16(), 4'b0100);
    step();
    check("single_release", out16(), 4'b0001);

    // Timeout on HOLD_MAX=4: GNT1 high for exactly 4 cycles, then GNT3.
    {if4.REQ3, if4.REQ2, if4.REQ1} = 3'b001;
    step();
    check("to_grant", out4(), 4'b0010);
    {if4.REQ3, if4.REQ2, if4.REQ1} = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("to_hold_%0d", i), out4(), 4'b0010);
    end
    step();
    check("to_preempt", out4(), 4'b1000);
    step();
    check("to_own3_a", out4(), 4'b1000);
    step();
    check("to_own3_b", out4(), 4'b1000);
    {if4.REQ3, if4.REQ2, if4.REQ1} = 3'b001;
    step();
    check("to_regain1", out4(), 4'b0010);
    {if4.REQ3, if4.REQ2, if4.REQ1} = 3'b000;
    step();
    check("to_idle", out4(), 4'b0001);

    // HOLD_MAX=0: REQ1 and REQ2 held since reset release, GNT1 never preempted.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out0() !== 4'b0010) bad++;
    end
    check_int("nohold_bad_cycles", bad, 0);

    // Mid-ownership reset: GNT3 drops asynchronously, pointer returns to 3.
    {if16.REQ3, if16.REQ2, if16.REQ1} = 3'b100;
    step();
    check("midrst_own3", out16(), 4'b1000);
    #2;
    rn = 1'b0;
    #1;
    check("midrst_async", out16(), 4'b0001);
    check("midrst_async_0", out0(), 4'b0001);
    {if16.REQ3, if16.REQ2, if16.REQ1} = 3'b111;
    step();
    check("midrst_held", out16(), 4'b0001);
    rn = 1'b1;
    step();
    check("midrst_ptr", out16(), 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
